// File: rtl/exp4_unidade_controle.sv
// Moore control FSM for the memory game round: start, per-move register,
// compare and advance, ending in a win or lose state.
module exp4_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        inicial       = 4'b0000,
        preparacao    = 4'b0001,
        espera_jogada = 4'b0010,
        registra      = 4'b0100,
        comparacao    = 4'b0101,
        proximo       = 4'b0110,
        fim_acerto    = 4'b1010,
        fim_erro      = 4'b1110
    } estado_t;

    estado_t estado;
    estado_t proximo_estado;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= inicial;
        end else begin
            estado <= proximo_estado;
        end
    end

    always_comb begin
        proximo_estado = inicial;
        case (estado)
            inicial:
                proximo_estado = iniciar ? preparacao : inicial;
            preparacao:
                proximo_estado = espera_jogada;
            espera_jogada:
                proximo_estado = jogada_feita ? registra : espera_jogada;
            registra:
                proximo_estado = comparacao;
            // a wrong move ends the round even on the last address
            comparacao: begin
                if (!igual) begin
                    proximo_estado = fim_erro;
                end else if (fimC) begin
                    proximo_estado = fim_acerto;
                end else begin
                    proximo_estado = proximo;
                end
            end
            proximo:
                proximo_estado = espera_jogada;
            fim_acerto:
                proximo_estado = iniciar ? preparacao : fim_acerto;
            fim_erro:
                proximo_estado = iniciar ? preparacao : fim_erro;
            default:
                proximo_estado = inicial;
        endcase
    end

    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        case (estado)
            preparacao: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            registra:
                registraR = 1'b1;
            proximo:
                contaC = 1'b1;
            fim_acerto: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            fim_erro: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Self-checking bench for exp4_unidade_controle: directed round scenarios
// plus randomized play against a round-level reference model.
module tb_exp4_unidade_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada_feita;
    logic       igual;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;

    exp4_unidade_controle dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .jogada_feita(jogada_feita),
        .igual       (igual),
        .fimC        (fimC),
        .zeraC       (zeraC),
        .contaC      (contaC),
        .zeraR       (zeraR),
        .registraR   (registraR),
        .pronto      (pronto),
        .acertou     (acertou),
        .errou       (errou),
        .db_estado   (db_estado)
    );

    always #5 clock = ~clock;

    // Round-level phases of the game, not the DUT encoding
    localparam int IDLE = 0;
    localparam int PREP = 1;
    localparam int WAIT = 2;
    localparam int LOAD = 3;
    localparam int JUDGE = 4;
    localparam int ADV = 5;
    localparam int WON = 6;
    localparam int LOST = 7;

    int ph = IDLE;

    function automatic logic [10:0] expv();
        logic [3:0] c;
        logic [6:0] o;
        c = 4'b0000;
        o = 7'b0;
        case (ph)
            PREP:  begin c = 4'b0001; o = 7'b1010000; end
            WAIT:  begin c = 4'b0010; o = 7'b0000000; end
            LOAD:  begin c = 4'b0100; o = 7'b0001000; end
            JUDGE: begin c = 4'b0101; o = 7'b0000000; end
            ADV:   begin c = 4'b0110; o = 7'b0100000; end
            WON:   begin c = 4'b1010; o = 7'b0000110; end
            LOST:  begin c = 4'b1110; o = 7'b0000101; end
            default: ;
        endcase
        return {c, o};
    endfunction

    function automatic logic [10:0] obsv();
        return {db_estado, zeraC, contaC, zeraR, registraR,
                pronto, acertou, errou};
    endfunction

    task automatic step(input logic r, input logic ini,
                        input logic jf, input logic ig,
                        input logic fc);
        reset = r;
        iniciar = ini;
        jogada_feita = jf;
        igual = ig;
        fimC = fc;
        @(posedge clock);
        if (r) begin
            ph = IDLE;
        end else begin
            case (ph)
                IDLE:  if (ini) ph = PREP;
                PREP:  ph = WAIT;
                WAIT:  if (jf) ph = LOAD;
                LOAD:  ph = JUDGE;
                JUDGE: ph = !ig ? LOST : (fc ? WON : ADV);
                ADV:   ph = WAIT;
                WON:   if (ini) ph = PREP;
                LOST:  if (ini) ph = PREP;
                default: ph = IDLE;
            endcase
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0);
            checks++;
            if (obsv() !== 11'b0) begin
                errors++;
                $display("FAIL reset_hold got=%b want=%b", obsv(), 11'b0);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, $urandom_range(0, 1), 1, 1);
            checks++;
            if (obsv() !== expv() || db_estado !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle got=%b want=%b", obsv(), expv());
            end
        end
    endtask

    task automatic test_start();
        step(0, 1, 0, 0, 0);
        checks++;
        if (obsv() !== expv() || db_estado !== 4'b0001) begin
            errors++;
            $display("FAIL start_prep got=%b want=%b", obsv(), expv());
        end
        step(0, 1, 0, 0, 0);
        checks++;
        if (obsv() !== expv() || db_estado !== 4'b0010) begin
            errors++;
            $display("FAIL start_wait got=%b want=%b", obsv(), expv());
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (obsv() !== expv()) begin
            errors++;
            $display("FAIL start_stay got=%b want=%b", obsv(), expv());
        end
    endtask

    task automatic test_correct_move();
        logic [3:0] seq [4];
        seq[0] = 4'b0100;
        seq[1] = 4'b0101;
        seq[2] = 4'b0110;
        seq[3] = 4'b0010;
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (db_estado !== seq[1]) begin
            errors++;
            $display("FAIL move_prefix got=%b want=%b", db_estado, seq[1]);
        end
        step(0, 0, 0, 1, 0);
        checks++;
        if (obsv() !== expv() || db_estado !== seq[2] || contaC !== 1'b1) begin
            errors++;
            $display("FAIL move_adv got=%b want=%b", obsv(), expv());
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (obsv() !== expv() || db_estado !== seq[3]) begin
            errors++;
            $display("FAIL move_back got=%b want=%b", obsv(), expv());
        end
    endtask

    task automatic test_full_round();
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int m = 0; m < 16; m++) begin
            step(0, 0, 1, 0, 0);
            checks++;
            if (obsv() !== expv() || registraR !== 1'b1) begin
                errors++;
                $display("FAIL round_load%0d got=%b want=%b", m, obsv(), expv());
            end
            step(0, 1, 0, 0, 0);
            step(0, 1, 0, 1, (m == 15));
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("FAIL round_cmp%0d got=%b want=%b", m, obsv(), expv());
            end
            if (m != 15) step(0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, $urandom_range(0, 1), 0, 0);
            checks++;
            if (obsv() !== expv() || db_estado !== 4'b1010 ||
                {pronto, acertou, errou} !== 3'b110) begin
                errors++;
                $display("FAIL round_won got=%b want=%b", obsv(), expv());
            end
        end
        step(0, 1, 0, 0, 0);
        checks++;
        if (db_estado !== 4'b0001) begin
            errors++;
            $display("FAIL round_restart got=%b want=0001", db_estado);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_wrong_move();
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        checks++;
        if (obsv() !== expv() || db_estado !== 4'b1110 ||
            {pronto, acertou, errou} !== 3'b101) begin
            errors++;
            $display("FAIL wrong_lost got=%b want=%b", obsv(), expv());
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (db_estado !== 4'b1110) begin
            errors++;
            $display("FAIL wrong_hold got=%b want=1110", db_estado);
        end
        step(0, 1, 0, 0, 0);
        checks++;
        if (obsv() !== expv() || db_estado !== 4'b0001) begin
            errors++;
            $display("FAIL wrong_restart got=%b want=%b", obsv(), expv());
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_abort();
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (db_estado !== 4'b0101) begin
            errors++;
            $display("FAIL abort_setup got=%b want=0101", db_estado);
        end
        #1 reset = 1'b1;
        ph = IDLE;
        #1;
        checks++;
        if (obsv() !== 11'b0) begin
            errors++;
            $display("FAIL abort_async got=%b want=%b", obsv(), 11'b0);
        end
        step(0, 1, 0, 0, 0);
        checks++;
        if (obsv() !== expv() || db_estado !== 4'b0001) begin
            errors++;
            $display("FAIL abort_first got=%b want=%b", obsv(), expv());
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_stray_pulse();
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        checks++;
        if (db_estado === 4'b0100 || obsv() !== expv()) begin
            errors++;
            $display("FAIL stray_adv got=%b want=%b", obsv(), expv());
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (db_estado !== 4'b0010) begin
            errors++;
            $display("FAIL stray_queued got=%b want=0010", db_estado);
        end
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        checks++;
        if (db_estado !== 4'b0101) begin
            errors++;
            $display("FAIL stray_load got=%b want=0101", db_estado);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 5) == 0));
            checks++;
            if (obsv() !== expv()) begin
                errors++;
                $display("FAIL random%0d got=%b want=%b", i, obsv(), expv());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        iniciar = 1'b0;
        jogada_feita = 1'b0;
        igual = 1'b0;
        fimC = 1'b0;
        #2;
        checks++;
        if (obsv() !== 11'b0) begin
            errors++;
            $display("FAIL reset_async got=%b want=%b", obsv(), 11'b0);
        end
        test_reset();
        test_start();
        test_correct_move();
        test_wrong_move();
        test_full_round();
        test_abort();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        test_stray_pulse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
